systolic_sequencer: RTL and testbench
=====================================

SYSTOLIC_SEQUENCER -- requirements
Module: systolic_sequencer

Interface
REQ-001 SHALL have parameters: DATA_W, default 8, operand width; AXIS_W, default 3, width of the K-length and tile-address fields.
REQ-002 SHALL have ports:
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
REQ-003 SHALL have the operand load port:
- ld_we  in  1  load strobe.
- ld_ready  out  1  load accepted this cycle.
- ld_lane  in  2  target lane: 0=A row0, 1=A row1, 2=B col0, 3=B col1.
- ld_idx  in  AXIS_W  element index t.
- ld_data  in  DATA_W  element value.
REQ-004 SHALL have the job port:
- start_valid  in  1  job request.
- start_ready  out  1  job can be accepted.
- start_k  in  AXIS_W  inner dimension K, 0..7.
- start_tile  in  AXIS_W  result address.
REQ-005 SHALL have the array drive outputs:
- a1, a2, b1, b2  out  DATA_W each  skewed operands.
- clear1..clear4  out  1 each  PE accumulator clears.
REQ-006 SHALL have the result and status outputs:
- res_we  out  1  result write strobe.
- res_addr  out  AXIS_W  result address.
- busy  out  1  job in progress.
- done  out  1  one-cycle completion pulse.

Function
REQ-007 SHALL hold a 4-lane x 8-entry x DATA_W operand buffer; lane index sel -> A0[t], A1[t], B0[t], B1[t].
REQ-008 ld_ready SHALL equal 1 only in IDLE; a write SHALL occur on a clk edge when ld_we and ld_ready; ld_we SHALL be ignored otherwise.
REQ-009 start_ready SHALL equal 1 only in IDLE; on start_valid & start_ready, start_k and start_tile SHALL be latched and the FSM SHALL enter CLEAR.
REQ-010 A load and a start in the same IDLE cycle SHALL both take effect; the loaded value SHALL be visible to that job.
REQ-011 The FSM SHALL have states IDLE -> CLEAR (1 cycle) -> FEED (K+1 cycles, counter t = 0..K) -> DRAIN (2 cycles) -> WRITE (1 cycle) -> IDLE.
REQ-012 In CLEAR, clear1..clear4 SHALL be 1 and all operands 0; clears SHALL be 0 in all other states.
REQ-013 In FEED, the operand outputs SHALL be:
- a1 = A0[t] if t<K, else 0.
- b1 = B0[t] if t<K, else 0.
- a2 = A1[t-1] if 1<=t<=K, else 0.
- b2 = B1[t-1] if 1<=t<=K, else 0.
REQ-014 Operands SHALL be 0 in IDLE, CLEAR, DRAIN and WRITE.
REQ-015 In WRITE, res_we=1, res_addr=latched start_tile and done=1 for exactly that cycle.
REQ-016 busy SHALL be 1 in every state except IDLE.
REQ-017 K=0 SHALL run FEED for 1 cycle of all-zero operands; total 5 cycles; results 0.
REQ-018 Latency: with the accepting edge followed by cycle 0 = CLEAR, WRITE/done SHALL occur in cycle K+4.
REQ-019 Arithmetic: no arithmetic in this block; PE accumulation wraps modulo 2^(2*DATA_W).
REQ-020 start_valid while busy SHALL be held off (start_ready=0), not dropped; a new job MAY be accepted in the IDLE cycle after WRITE.

Reset
REQ-021 reset low SHALL, asynchronously:
- force IDLE;
- clear the t counter, latched K and latched tile;
- clear the operand buffer to 0;
- force all outputs to 0 except ld_ready=1 and start_ready=1 after release.
REQ-022 Reset mid-job SHALL abort with no res_we or done; the first cycle after release SHALL be IDLE.

Verification
REQ-023 Load A=[[1,2],[3,4]], B0=[5,7], B1=[6,8]; start K=2, tile=5 -> cycle 0 clears=1111; cycles 1..3 give a1=1,2,0 / a2=0,3,4 / b1=5,7,0 / b2=0,6,8; cycle 6 res_we=1, res_addr=5, done=1; array yields c1..c4=19,22,43,50.
REQ-024 start K=0, tile=2 -> one clear cycle, operands all 0, res_we/done in cycle 4, c1..c4=0.
REQ-025 All operands 255, K=7 -> WRITE in cycle 11; each c=61959 (455175 mod 65536).
REQ-026 Pulse ld_we and start_valid while busy -> ld_ready=0, buffer unchanged; start_ready=0 until after WRITE; a held start is accepted in the next IDLE cycle.
REQ-027 Assert reset in FEED cycle 2 of a K=5 job -> outputs 0 at once, no res_we/done, buffer reads 0; a new K=1 job after release completes in cycle 5.
REQ-028 Same-cycle ld_we (lane 0, idx 0, data 9) with start K=1 -> first FEED cycle a1=9.

Source files
------------

// File: rtl/systolic_sequencer.sv
// Operand buffer and sequencer for a 2x2 output-stationary systolic array:
// clears the PEs, streams skewed A/B operands for K steps, drains, then writes.
module systolic_sequencer #(
  parameter int DATA_W = 8,
  parameter int AXIS_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ld_we,
  output logic              ld_ready,
  input  logic [1:0]        ld_lane,
  input  logic [AXIS_W-1:0] ld_idx,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              start_valid,
  output logic              start_ready,
  input  logic [AXIS_W-1:0] start_k,
  input  logic [AXIS_W-1:0] start_tile,
  output logic [DATA_W-1:0] a1,
  output logic [DATA_W-1:0] a2,
  output logic [DATA_W-1:0] b1,
  output logic [DATA_W-1:0] b2,
  output logic              clear1,
  output logic              clear2,
  output logic              clear3,
  output logic              clear4,
  output logic              res_we,
  output logic [AXIS_W-1:0] res_addr,
  output logic              busy,
  output logic              done
);

  localparam int DEPTH = 1 << AXIS_W;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_FEED  = 3'd2,
    S_DRAIN = 3'd3,
    S_WRITE = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [AXIS_W-1:0]   t_q, t_d;
  logic [AXIS_W-1:0]   k_q, k_d;
  logic [AXIS_W-1:0]   tile_q, tile_d;
  logic [DATA_W-1:0]   buf_q [4][DEPTH];
  logic [DATA_W-1:0]   buf_d [4][DEPTH];

  logic [DATA_W-1:0]   a1_q, a1_d, a2_q, a2_d, b1_q, b1_d, b2_q, b2_d;
  logic                clear_q, clear_d;
  logic                res_we_q, res_we_d;
  logic [AXIS_W-1:0]   res_addr_q, res_addr_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                ld_ready_q, ld_ready_d;
  logic                start_ready_q, start_ready_d;

  logic                ld_fire_s;
  logic                start_fire_s;
  logic                feed_s;
  logic [AXIS_W-1:0]   t_m1_s;

  assign ld_fire_s    = ld_we & ld_ready_q;
  assign start_fire_s = start_valid & start_ready_q;

  // Operand buffer write port; loads are only accepted while idle.
  always_comb begin
    for (int l = 0; l < 4; l++) begin
      for (int e = 0; e < DEPTH; e++) begin
        buf_d[l][e] = (ld_fire_s && (ld_lane == 2'(l)) && (ld_idx == AXIS_W'(e))) ?
                      ld_data : buf_q[l][e];
      end
    end
  end

  // Job FSM: CLEAR, FEED t=0..K, DRAIN for two cycles (t reused), WRITE.
  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    k_d     = k_q;
    tile_d  = tile_q;
    case (state_q)
      S_IDLE: begin
        if (start_fire_s) begin
          state_d = S_CLEAR;
          k_d     = start_k;
          tile_d  = start_tile;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CLEAR: begin
        state_d = S_FEED;
        t_d     = {AXIS_W{1'b0}};
      end
      S_FEED: begin
        if (t_q == k_q) begin
          state_d = S_DRAIN;
          t_d     = {AXIS_W{1'b0}};
        end else begin
          t_d     = t_q + AXIS_W'(1);
        end
      end
      S_DRAIN: begin
        if (t_q == AXIS_W'(1)) begin
          state_d = S_WRITE;
          t_d     = {AXIS_W{1'b0}};
        end else begin
          t_d     = t_q + AXIS_W'(1);
        end
      end
      S_WRITE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        t_d     = {AXIS_W{1'b0}};
      end
    endcase
  end

  assign feed_s = (state_d == S_FEED);
  assign t_m1_s = t_d - AXIS_W'(1);

  // Outputs are decoded from the next state so they register in step with it;
  // buf_q is safe to read because loads never overlap a job.
  always_comb begin
    a1_d = {DATA_W{1'b0}};
    b1_d = {DATA_W{1'b0}};
    a2_d = {DATA_W{1'b0}};
    b2_d = {DATA_W{1'b0}};
    if (feed_s && (t_d < k_d)) begin
      a1_d = buf_q[0][t_d];
      b1_d = buf_q[2][t_d];
    end else begin
      a1_d = {DATA_W{1'b0}};
      b1_d = {DATA_W{1'b0}};
    end
    if (feed_s && (t_d != {AXIS_W{1'b0}}) && (t_d <= k_d)) begin
      a2_d = buf_q[1][t_m1_s];
      b2_d = buf_q[3][t_m1_s];
    end else begin
      a2_d = {DATA_W{1'b0}};
      b2_d = {DATA_W{1'b0}};
    end
    clear_d       = (state_d == S_CLEAR);
    res_we_d      = (state_d == S_WRITE);
    done_d        = (state_d == S_WRITE);
    res_addr_d    = (state_d == S_WRITE) ? tile_d : {AXIS_W{1'b0}};
    busy_d        = (state_d != S_IDLE);
    ld_ready_d    = (state_d == S_IDLE);
    start_ready_d = (state_d == S_IDLE);
  end

  // State, counters, buffer and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      t_q           <= {AXIS_W{1'b0}};
      k_q           <= {AXIS_W{1'b0}};
      tile_q        <= {AXIS_W{1'b0}};
      for (int l = 0; l < 4; l++) begin
        for (int e = 0; e < DEPTH; e++) begin
          buf_q[l][e] <= {DATA_W{1'b0}};
        end
      end
      a1_q          <= {DATA_W{1'b0}};
      a2_q          <= {DATA_W{1'b0}};
      b1_q          <= {DATA_W{1'b0}};
      b2_q          <= {DATA_W{1'b0}};
      clear_q       <= 1'b0;
      res_we_q      <= 1'b0;
      res_addr_q    <= {AXIS_W{1'b0}};
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      ld_ready_q    <= 1'b1;
      start_ready_q <= 1'b1;
    end else begin
      state_q       <= state_d;
      t_q           <= t_d;
      k_q           <= k_d;
      tile_q        <= tile_d;
      buf_q         <= buf_d;
      a1_q          <= a1_d;
      a2_q          <= a2_d;
      b1_q          <= b1_d;
      b2_q          <= b2_d;
      clear_q       <= clear_d;
      res_we_q      <= res_we_d;
      res_addr_q    <= res_addr_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      ld_ready_q    <= ld_ready_d;
      start_ready_q <= start_ready_d;
    end
  end

  assign a1          = a1_q;
  assign a2          = a2_q;
  assign b1          = b1_q;
  assign b2          = b2_q;
  assign clear1      = clear_q;
  assign clear2      = clear_q;
  assign clear3      = clear_q;
  assign clear4      = clear_q;
  assign res_we      = res_we_q;
  assign res_addr    = res_addr_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign ld_ready    = ld_ready_q;
  assign start_ready = start_ready_q;

endmodule

// File: tb/tb_systolic_sequencer.sv
// Randomised self-checking bench: per-cycle trace against the job timeline and
// a 2x2 PE array fed by the DUT, compared with a direct matrix product.
module tb_systolic_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       ld_we, ld_ready;
  logic [1:0] ld_lane;
  logic [2:0] ld_idx;
  logic [7:0] ld_data;
  logic       start_valid, start_ready;
  logic [2:0] start_k, start_tile;
  logic [7:0] a1, a2, b1, b2;
  logic       clear1, clear2, clear3, clear4;
  logic       res_we;
  logic [2:0] res_addr;
  logic       busy, done;

  int checks   = 0;
  int failures = 0;

  logic [7:0]  mem [4][8];
  logic [15:0] pe11, pe12, pe21, pe22;
  logic [7:0]  a1_dl, a2_dl, b1_dl, b2_dl;

  systolic_sequencer #(.DATA_W(8), .AXIS_W(3)) dut (
    .clk(clk), .reset(reset),
    .ld_we(ld_we), .ld_ready(ld_ready), .ld_lane(ld_lane), .ld_idx(ld_idx), .ld_data(ld_data),
    .start_valid(start_valid), .start_ready(start_ready), .start_k(start_k), .start_tile(start_tile),
    .a1(a1), .a2(a2), .b1(b1), .b2(b2),
    .clear1(clear1), .clear2(clear2), .clear3(clear3), .clear4(clear4),
    .res_we(res_we), .res_addr(res_addr), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // 2x2 output-stationary array; skew registers pass a east and b south.
  always @(negedge clk) begin
    pe11  <= clear1 ? 16'd0 : pe11 + 16'(a1) * 16'(b1);
    pe12  <= clear2 ? 16'd0 : pe12 + 16'(a1_dl) * 16'(b2);
    pe21  <= clear3 ? 16'd0 : pe21 + 16'(a2) * 16'(b1_dl);
    pe22  <= clear4 ? 16'd0 : pe22 + 16'(a2_dl) * 16'(b2_dl);
    a1_dl <= a1;
    a2_dl <= a2;
    b1_dl <= b1;
    b2_dl <= b2;
  end

  task automatic load(input int lane, input int idx, input logic [7:0] data);
    ld_we = 1'b1; ld_lane = 2'(lane); ld_idx = 3'(idx); ld_data = data;
    @(posedge clk); #1;
    ld_we = 1'b0;
    mem[lane][idx] = data;
  endtask

  task automatic start_job(input int k, input logic [2:0] tile);
    int n;
    n = 0;
    while (start_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n >= 50) begin
      failures++;
      $display("FAIL start_wait start_ready=%b required=1 within 50 cycles", start_ready);
    end
    start_valid = 1'b1; start_k = 3'(k); start_tile = tile;
    @(posedge clk); #1;
    start_valid = 1'b0;
  endtask

  // Follows an accepting edge: checks cycles 0..K+4, the IDLE cycle after, then results.
  task automatic check_trace(input int k, input logic [2:0] tile);
    logic [43:0] act, exp;
    logic [7:0]  ea1, ea2, eb1, eb2;
    logic        clr, wr, idle;
    logic [2:0]  eaddr;
    logic [31:0] s1, s2, s3, s4;
    int t;
    for (int c = 0; c <= k + 5; c++) begin
      @(negedge clk);
      t = c - 1;
      ea1 = 8'd0; eb1 = 8'd0; ea2 = 8'd0; eb2 = 8'd0;
      if (c >= 1 && c <= k + 1) begin
        if (t < k) begin
          ea1 = mem[0][t];
          eb1 = mem[2][t];
        end
        if (t >= 1) begin
          ea2 = mem[1][t-1];
          eb2 = mem[3][t-1];
        end
      end
      clr   = (c == 0);
      wr    = (c == k + 4);
      idle  = (c == k + 5);
      eaddr = wr ? tile : 3'd0;
      exp = {ea1, ea2, eb1, eb2, {4{clr}}, wr, eaddr, ~idle, wr, idle, idle};
      act = {a1, a2, b1, b2, clear1, clear2, clear3, clear4, res_we, res_addr,
             busy, done, ld_ready, start_ready};
      checks++;
      if (act !== exp) begin
        failures++;
        $display("FAIL trace k=%0d cycle=%0d got=%h want=%h", k, c, act, exp);
      end
    end
    s1 = 0; s2 = 0; s3 = 0; s4 = 0;
    for (int i = 0; i < k; i++) begin
      s1 += mem[0][i] * mem[2][i];
      s2 += mem[0][i] * mem[3][i];
      s3 += mem[1][i] * mem[2][i];
      s4 += mem[1][i] * mem[3][i];
    end
    checks++;
    if ({pe11, pe12, pe21, pe22} !== {s1[15:0], s2[15:0], s3[15:0], s4[15:0]}) begin
      failures++;
      $display("FAIL results k=%0d got=%0d,%0d,%0d,%0d want=%0d,%0d,%0d,%0d", k,
               pe11, pe12, pe21, pe22, s1[15:0], s2[15:0], s3[15:0], s4[15:0]);
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    for (int l = 0; l < 4; l++) for (int e = 0; e < 8; e++) mem[l][e] = 8'd0;
    @(negedge clk);
    checks++;
    if ({a1, a2, b1, b2, clear1, clear2, clear3, clear4, res_we, res_addr, busy, done,
         ld_ready, start_ready} !== {40'd0, 2'b11}) begin
      failures++;
      $display("FAIL reset_state got a1=%h a2=%h b1=%h b2=%h busy=%b done=%b ldr=%b str=%b want zeros, ready=1",
               a1, a2, b1, b2, busy, done, ld_ready, start_ready);
    end
  endtask

  task automatic test_example;
    load(0, 0, 8'd1); load(0, 1, 8'd2);
    load(1, 0, 8'd3); load(1, 1, 8'd4);
    load(2, 0, 8'd5); load(2, 1, 8'd7);
    load(3, 0, 8'd6); load(3, 1, 8'd8);
    start_job(2, 3'd5);
    check_trace(2, 3'd5);
    checks++;
    if ({pe11, pe12, pe21, pe22} !== {16'd19, 16'd22, 16'd43, 16'd50}) begin
      failures++;
      $display("FAIL example_values got=%0d,%0d,%0d,%0d want=19,22,43,50", pe11, pe12, pe21, pe22);
    end
  endtask

  task automatic test_k0;
    start_job(0, 3'd2);
    check_trace(0, 3'd2);
  endtask

  task automatic test_saturate;
    for (int l = 0; l < 4; l++) for (int e = 0; e < 8; e++) load(l, e, 8'd255);
    start_job(7, 3'd7);
    check_trace(7, 3'd7);
    checks++;
    if ({pe11, pe12, pe21, pe22} !== {4{16'd61959}}) begin
      failures++;
      $display("FAIL saturate_values got=%0d,%0d,%0d,%0d want=61959 each", pe11, pe12, pe21, pe22);
    end
  endtask

  task automatic test_random;
    int k;
    logic [2:0] tile;
    for (int j = 0; j < 4; j++) begin
      for (int l = 0; l < 4; l++) for (int e = 0; e < 8; e++) load(l, e, 8'($urandom));
      k    = $urandom_range(0, 7);
      tile = 3'($urandom_range(0, 7));
      start_job(k, tile);
      check_trace(k, tile);
    end
  endtask

  task automatic test_busy_holdoff;
    start_job(3, 3'd1);
    fork
      check_trace(3, 3'd1);
      begin
        ld_we = 1'b1; ld_lane = 2'd0; ld_idx = 3'd0; ld_data = mem[0][0] ^ 8'hA5;
        start_valid = 1'b1; start_k = 3'd2; start_tile = 3'd4;
        repeat (3) @(posedge clk);
        #1 ld_we = 1'b0;
      end
    join
    @(posedge clk); #1;
    start_valid = 1'b0;
    check_trace(2, 3'd4);
  endtask

  task automatic test_reset_mid_job;
    for (int l = 0; l < 4; l++) load(l, 0, 8'(l + 11));
    start_job(5, 3'd3);
    repeat (4) @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if ({a1, a2, b1, b2, clear1, res_we, res_addr, busy, done} !== 39'd0) begin
      failures++;
      $display("FAIL reset_abort got a1=%h a2=%h b1=%h b2=%h we=%b busy=%b done=%b want all 0",
               a1, a2, b1, b2, res_we, busy, done);
    end
    for (int l = 0; l < 4; l++) for (int e = 0; e < 8; e++) mem[l][e] = 8'd0;
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      checks++;
      if ({res_we, done, busy, ld_ready, start_ready} !== 5'b00011) begin
        failures++;
        $display("FAIL post_reset_idle cycle=%0d got we/done/busy/ldr/str=%b want 00011",
                 c, {res_we, done, busy, ld_ready, start_ready});
      end
    end
    start_job(1, 3'd6);
    check_trace(1, 3'd6);
  endtask

  task automatic test_same_cycle;
    load(2, 0, 8'd3);
    ld_we = 1'b1; ld_lane = 2'd0; ld_idx = 3'd0; ld_data = 8'd9;
    start_valid = 1'b1; start_k = 3'd1; start_tile = 3'd0;
    @(posedge clk); #1;
    ld_we = 1'b0; start_valid = 1'b0;
    mem[0][0] = 8'd9;
    check_trace(1, 3'd0);
  endtask

  initial begin
    ld_we = 1'b0; ld_lane = 2'd0; ld_idx = 3'd0; ld_data = 8'd0;
    start_valid = 1'b0; start_k = 3'd0; start_tile = 3'd0;
    test_reset;
    test_example;
    test_k0;
    test_saturate;
    test_random;
    test_busy_holdoff;
    test_reset_mid_job;
    test_same_cycle;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
